// File: rtl/id_pkg.sv
// Shared decode types for the instruction-decode pipe stage: instruction classes,
// RV32I major opcodes and the decoded-entry record buffered by id_pipe_stage.
package id_pkg;

  typedef enum logic [3:0] {
    IT_R       = 4'd0,
    IT_I       = 4'd1,
    IT_S       = 4'd2,
    IT_B       = 4'd3,
    IT_U       = 4'd4,
    IT_J       = 4'd5,
    IT_UNKNOWN = 4'd6
  } instr_type_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic [31:0] imm;
    instr_type_t instr_type;
    logic        rd_we;
    logic        illegal;
  } id_entry_t;

  function automatic instr_type_t classify_opcode(input logic [6:0] op);
    instr_type_t t;
    case (op)
      OP_OP:                                          t = IT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:  t = IT_I;
      OP_STORE:                                       t = IT_S;
      OP_BRANCH:                                      t = IT_B;
      OP_LUI, OP_AUIPC:                               t = IT_U;
      OP_JAL:                                         t = IT_J;
      default:                                        t = IT_UNKNOWN;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I field decoder. Illegal-encoding detection is built only
// when ID_ILLEGAL_CHK_EN is defined; otherwise illegal is tied low.
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0] i_instr,
  output id_entry_t   o_entry
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  instr_type_t w_type;
  logic [31:0] w_imm;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_illegal;
  logic        w_rd_we;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_type   = classify_opcode(w_opcode);

  always_comb begin
    w_imm = '0;
    case (w_type)
      IT_I: w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IT_S: w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IT_B: w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      IT_U: w_imm = {i_instr[31:12], 12'b0};
      IT_J: w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // Register indices are zeroed where the format has no such field.
  always_comb begin
    w_rs1 = i_instr[19:15];
    w_rs2 = i_instr[24:20];
    w_rd  = i_instr[11:7];
    if (w_type inside {IT_U, IT_J, IT_UNKNOWN}) w_rs1 = '0;
    if (!(w_type inside {IT_R, IT_S, IT_B}))    w_rs2 = '0;
    if (w_type inside {IT_S, IT_B, IT_UNKNOWN}) w_rd  = '0;
  end

`ifdef ID_ILLEGAL_CHK_EN
  always_comb begin
    w_illegal = (i_instr[1:0] != 2'b11) || (w_type == IT_UNKNOWN);
    case (w_opcode)
      OP_OP: begin
        if (!((w_funct7 == 7'b0000000) ||
              ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))))
          w_illegal = 1'b1;
      end
      OP_IMM: begin
        if ((w_funct3 == 3'b001) && (w_funct7 != 7'b0000000))
          w_illegal = 1'b1;
        if ((w_funct3 == 3'b101) && (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000))
          w_illegal = 1'b1;
      end
      OP_BRANCH: if ((w_funct3 == 3'b010) || (w_funct3 == 3'b011)) w_illegal = 1'b1;
      OP_LOAD:   if ((w_funct3 == 3'b011) || (w_funct3 >= 3'b110)) w_illegal = 1'b1;
      OP_STORE:  if (w_funct3 >= 3'b011) w_illegal = 1'b1;
      default:   ;
    endcase
  end
`else
  assign w_illegal = 1'b0;
`endif

  assign w_rd_we = (w_rd != 5'd0) && (w_type inside {IT_R, IT_I, IT_U, IT_J}) && !w_illegal;

  always_comb begin
    o_entry            = '0;
    o_entry.instr      = i_instr;
    o_entry.opcode     = w_opcode;
    o_entry.funct3     = w_funct3;
    o_entry.funct7     = w_funct7;
    o_entry.rs1_idx    = w_rs1;
    o_entry.rs2_idx    = w_rs2;
    o_entry.rd_idx     = w_rd;
    o_entry.imm        = w_imm;
    o_entry.instr_type = w_type;
    o_entry.rd_we      = w_rd_we;
    o_entry.illegal    = w_illegal;
  end

endmodule

// File: rtl/id_pipe_stage.sv
// Decode pipe stage: decodes on entry and buffers entries in a BUF_DEPTH FIFO.
// Optional illegal-encoding check is enabled with the ID_ILLEGAL_CHK_EN macro.
module id_pipe_stage
  import id_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1_idx,
  output logic [4:0]      rs2_idx,
  output logic [4:0]      rd_idx,
  output logic [31:0]     imm,
  output logic [3:0]      instr_type,
  output logic            rd_we,
  output logic            illegal
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  id_entry_t        w_dec;
  id_entry_t        w_head;
  logic [PC_W-1:0]  w_head_pc;
  logic             w_push;
  logic             w_pop;

  id_entry_t        r_entry_mem [BUF_DEPTH];
  logic [PC_W-1:0]  r_pc_mem    [BUF_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  id_decoder u_dec (
    .i_instr (in_instr),
    .o_entry (w_dec)
  );

  // Handshakes are masked while reset is held so nothing is exchanged in that cycle.
  assign in_ready  = rst && (r_count < CNT_W'(BUF_DEPTH));
  assign out_valid = rst && (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entry_mem[r_wr_ptr] <= w_dec;
      r_pc_mem[r_wr_ptr]    <= in_pc;
    end
  end

  assign w_head    = r_entry_mem[r_rd_ptr];
  assign w_head_pc = r_pc_mem[r_rd_ptr];

  always_comb begin
    out_pc     = '0;
    out_instr  = '0;
    opcode     = '0;
    funct3     = '0;
    funct7     = '0;
    rs1_idx    = '0;
    rs2_idx    = '0;
    rd_idx     = '0;
    imm        = '0;
    instr_type = '0;
    rd_we      = 1'b0;
    illegal    = 1'b0;
    if (out_valid) begin
      out_pc     = w_head_pc;
      out_instr  = w_head.instr;
      opcode     = w_head.opcode;
      funct3     = w_head.funct3;
      funct7     = w_head.funct7;
      rs1_idx    = w_head.rs1_idx;
      rs2_idx    = w_head.rs2_idx;
      rd_idx     = w_head.rd_idx;
      imm        = w_head.imm;
      instr_type = w_head.instr_type;
      rd_we      = w_head.rd_we;
      illegal    = w_head.illegal;
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed scenarios plus randomized traffic
// against a queue-based reference model with an arithmetic RV32I decoder.
module tb_id_pipe_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm;
  logic [3:0]  instr_type;
  logic        rd_we;
  logic        illegal;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;

  typedef struct {
    int          typ;
    logic [31:0] imm;
    int          rs1;
    int          rs2;
    int          rd;
    bit          ill;
    bit          we;
  } ref_t;

  txn_t mq[$];

  id_pipe_stage #(.PC_W(32), .BUF_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rd_idx     (rd_idx),
    .imm        (imm),
    .instr_type (instr_type),
    .rd_we      (rd_we),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t r;
    int op, f3, f7;
    bit s;
    op = int'(ins & 32'h7F);
    f3 = int'((ins >> 12) & 7);
    f7 = int'((ins >> 25) & 32'h7F);
    s  = ins[31];
    case (op)
      'h33:                         r.typ = 0;
      'h13, 'h03, 'h67, 'h73, 'h0F: r.typ = 1;
      'h23:                         r.typ = 2;
      'h63:                         r.typ = 3;
      'h37, 'h17:                   r.typ = 4;
      'h6F:                         r.typ = 5;
      default:                      r.typ = 6;
    endcase
    case (r.typ)
      1: r.imm = (s ? 32'hFFFFF000 : 32'h0) + (ins >> 20);
      2: r.imm = (s ? 32'hFFFFF000 : 32'h0) + ((ins >> 25) & 127) * 32 + ((ins >> 7) & 31);
      3: r.imm = (s ? 32'hFFFFF000 : 32'h0) + ((ins >> 7) & 1) * 2048
                 + ((ins >> 25) & 63) * 32 + ((ins >> 8) & 15) * 2;
      4: r.imm = ins & 32'hFFFFF000;
      5: r.imm = (s ? 32'hFFF00000 : 32'h0) + ((ins >> 12) & 255) * 4096
                 + ((ins >> 20) & 1) * 2048 + ((ins >> 21) & 1023) * 2;
      default: r.imm = 32'h0;
    endcase
    r.rs1 = (r.typ == 4 || r.typ == 5 || r.typ == 6) ? 0 : int'((ins >> 15) & 31);
    r.rs2 = (r.typ == 0 || r.typ == 2 || r.typ == 3) ? int'((ins >> 20) & 31) : 0;
    r.rd  = (r.typ == 2 || r.typ == 3 || r.typ == 6) ? 0 : int'((ins >> 7) & 31);
    r.ill = 1'b0;
`ifdef ID_ILLEGAL_CHK_EN
    if ((ins & 3) != 3 || r.typ == 6) r.ill = 1'b1;
    if (op == 'h33 && !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)))) r.ill = 1'b1;
    if (op == 'h13 && f3 == 1 && f7 != 0) r.ill = 1'b1;
    if (op == 'h13 && f3 == 5 && f7 != 0 && f7 != 'h20) r.ill = 1'b1;
    if (op == 'h63 && (f3 == 2 || f3 == 3)) r.ill = 1'b1;
    if (op == 'h03 && (f3 == 3 || f3 == 6 || f3 == 7)) r.ill = 1'b1;
    if (op == 'h23 && f3 >= 3) r.ill = 1'b1;
`endif
    r.we = (r.rd != 0) && (r.typ == 0 || r.typ == 1 || r.typ == 4 || r.typ == 5) && !r.ill;
    return r;
  endfunction

  // One clock: compare outputs with the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit   exp_ov, exp_ir, fin, fout;
    ref_t r;
    txn_t t;
    @(negedge clk);
    exp_ov = (rst === 1'b1) && (mq.size() != 0);
    exp_ir = (rst === 1'b1) && (mq.size() < DEPTH);
    check_val("out_valid", 64'(out_valid), 64'(exp_ov));
    check_val("in_ready", 64'(in_ready), 64'(exp_ir));
    if (exp_ov) begin
      t = mq[0];
      r = ref_decode(t.instr);
      check_val("out_pc", 64'(out_pc), 64'(t.pc));
      check_val("out_instr", 64'(out_instr), 64'(t.instr));
      check_val("opcode", 64'(opcode), 64'(t.instr & 32'h7F));
      check_val("funct3", 64'(funct3), 64'((t.instr >> 12) & 7));
      check_val("funct7", 64'(funct7), 64'(t.instr >> 25));
      check_val("instr_type", 64'(instr_type), 64'(r.typ));
      check_val("imm", 64'(imm), 64'(r.imm));
      check_val("rs1_idx", 64'(rs1_idx), 64'(r.rs1));
      check_val("rs2_idx", 64'(rs2_idx), 64'(r.rs2));
      check_val("rd_idx", 64'(rd_idx), 64'(r.rd));
      check_val("rd_we", 64'(rd_we), 64'(r.we));
      check_val("illegal", 64'(illegal), 64'(r.ill));
    end else begin
      check_val("idle_payload",
                {out_pc, out_instr} | 64'({opcode, funct3, funct7, rs1_idx, rs2_idx, rd_idx})
                | 64'({imm, instr_type, rd_we, illegal}), 64'h0);
    end
    fin  = in_valid && exp_ir;
    fout = exp_ov && out_ready;
    @(posedge clk);
    if (rst !== 1'b1 || flush) begin
      mq.delete();
    end else begin
      if (fout) void'(mq.pop_front());
      if (fin) mq.push_back('{pc: in_pc, instr: in_instr});
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit ordy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [11];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    ins = $urandom;
    if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
    return ins;
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    check_val("idle_in_ready", 64'(in_ready), 64'd1);

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 32'h100, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check_val("addi_valid", 64'(out_valid), 64'd1);
    check_val("addi_type", 64'(instr_type), 64'd1);
    check_val("addi_rd", 64'(rd_idx), 64'd1);
    check_val("addi_rs1", 64'(rs1_idx), 64'd0);
    check_val("addi_imm", 64'(imm), 64'd5);
    check_val("addi_rd_we", 64'(rd_we), 64'd1);
    out_ready = 1'b1;
    cycle();

    // sw then beq held back, then lui/jal; drain in order
    drive(1'b1, 32'h0020A423, 32'h200, 1'b0); cycle();
    drive(1'b1, 32'hFE000EE3, 32'h204, 1'b0); cycle();
    check_val("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h123452B7, 32'h208, 1'b0); cycle();
    check_val("stall_head_pc", 64'(out_pc), 64'h200);
    check_val("sw_imm", 64'(imm), 64'd8);
    drive(1'b0, 32'h0, 32'h0, 1'b1); cycle();
    check_val("beq_imm", 64'(imm), 64'hFFFFFFFC);
    check_val("beq_type", 64'(instr_type), 64'd3);
    cycle();
    drive(1'b1, 32'h123452B7, 32'h208, 1'b0); cycle();
    drive(1'b1, 32'h008000EF, 32'h20C, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check_val("lui_imm", 64'(imm), 64'h12345000);
    cycle();
    check_val("jal_imm", 64'(imm), 64'd8);
    check_val("jal_rd", 64'(rd_idx), 64'd1);
    cycle();

    // flush while full with a concurrent push
    drive(1'b1, 32'h00100113, 32'h300, 1'b0); cycle();
    drive(1'b1, 32'h00200193, 32'h304, 1'b0); cycle();
    drive(1'b1, 32'h00700393, 32'h308, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    check_val("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (2) cycle();

    // all-ones word
    drive(1'b1, 32'hFFFFFFFF, 32'h400, 1'b0); cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef ID_ILLEGAL_CHK_EN
    check_val("ones_illegal", 64'(illegal), 64'd1);
`else
    check_val("ones_illegal", 64'(illegal), 64'd0);
`endif
    check_val("ones_rd_we", 64'(rd_we), 64'd0);
    check_val("ones_type", 64'(instr_type), 64'd6);
    out_ready = 1'b1;
    cycle();

    // 20 back-to-back transfers through the wrapping pointers
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h00000013 | (32'(i) << 20) | (32'((i % 31) + 1) << 7), 32'h1000 + 32'(4 * i), 1'b1);
      cycle();
      check_val("stream_valid", 64'(out_valid), 64'd1);
      check_val("stream_pc", 64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    cycle();

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 79) != 0);
      cycle();
    end
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
